hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. It sits beside the IF/ID/EX/MEM/WB stages and owns every stage-enable and flush strobe. Its jobs are load-use stalls, control-transfer redirects (multi-cycle flush covering synchronous IMEM latency), data-memory wait freezes, and EX-stage operand forwarding selects. It also keeps a free-running stall-cycle performance counter.

Parameters:
IMEM_LATENCY, 1, extra cycles ifid_flush stays asserted after a redirect (wrong-path fetches already in flight); legal range 0..7
CNT_W, 32, width of perf_stall_cycles

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
id_rs1  in  5  source reg 1 of instr in ID
id_rs2  in  5  source reg 2 of instr in ID
ex_rs1  in  5  source reg 1 of instr in EX
ex_rs2  in  5  source reg 2 of instr in EX
ex_rd  in  5  dest reg of instr in EX
ex_mem_read  in  1  instr in EX is a load
ex_redirect  in  1  EX resolved taken branch or jump (level, held while EX frozen)
mem_rd  in  5  dest reg in MEM
mem_reg_write  in  1  MEM instr writes rd
mem_req  in  1  MEM stage has an active dmem access
dmem_ready  in  1  dmem completes access this cycle
wb_rd  in  5  dest reg in WB
wb_reg_write  in  1  WB instr writes rd
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID register loads NOP
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX register loads bubble
exmem_en  out  1  EX/MEM register enable
memwb_bubble  out  1  MEM/WB loads bubble (reg_write=0)
fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
fwd_b  out  2  EX operand B select, same encoding
perf_stall_cycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- State register: RUN, MEM_WAIT, REDIRECT. Flush counter fl_cnt [2:0]. Async reset: state=RUN, fl_cnt=0, perf_stall_cycles=0.
- Outputs are combinational from state and inputs. Default: all *_en=1, all flush/bubble=0, fwd=00.
- Priority per cycle: freeze > redirect > load-use.
- Freeze (mem_req && !dmem_ready, any state):
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1; no flushes.
  - RUN -> MEM_WAIT. MEM_WAIT holds until dmem_ready=1, which gives normal outputs that cycle and returns to RUN.
  - fl_cnt does not decrement while frozen.
- Redirect (ex_redirect=1, not frozen):
  - ifid_flush=1, idex_flush=1, pc_en=1 (PC loads target).
  - If IMEM_LATENCY>0: fl_cnt<=IMEM_LATENCY, state->REDIRECT.
  - In REDIRECT: ifid_flush=1, fl_cnt decrements, exit to RUN when fl_cnt reaches 1->0.
  - A new ex_redirect in REDIRECT reloads fl_cnt.
- Load-use (RUN or REDIRECT, not frozen, no redirect): ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle.
  - Self-clears next cycle because the load advances to MEM.
  - Suppressed when ex_redirect=1, since ID is wrong-path.
- Forwarding:
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Else 00. Same rule for fwd_b on ex_rs2. MEM beats WB on a double match.
  - Forwarding is evaluated regardless of freeze.
- perf_stall_cycles increments on every clk edge where pc_en=0 and wraps modulo 2^CNT_W.
- Reset mid-freeze or mid-redirect: immediate return to RUN, counter cleared; outputs revert to defaults while rstn=0.
- x0 is never a hazard or forwarding source.

Decomposition:
- Package core_pkg: hazard state enum (RUN/MEM_WAIT/REDIRECT), forwarding select localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module forward_unit: purely combinational, instantiated twice, once per operand.
- FSM, flush counter and perf counter stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; perf_stall_cycles 0->1.
- Load to x0: ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall; all enables 1.
- Redirect, IMEM_LATENCY=1: ex_redirect pulse -> cycle0 ifid_flush=idex_flush=1; cycle1 ifid_flush=1 only; cycle2 RUN defaults. With IMEM_LATENCY=0 -> flush one cycle only.
- Freeze: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 and memwb_bubble=1 for 3 cycles; normal on the ready cycle; perf counter +3. A concurrent ex_redirect and load-use are deferred until after the ready cycle.
- Forwarding priority: ex_rs1=7, mem_rd=7/mem_reg_write=1, wb_rd=7/wb_reg_write=1 -> fwd_a=10. Drop mem_reg_write -> fwd_a=01. ex_rs2=0 with matching rd=0 -> fwd_b=00.
- Async reset asserted mid-REDIRECT and mid-MEM_WAIT -> state RUN, perf_stall_cycles=0 without a clock edge; normal operation on release.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control types and forwarding select encodings
package core_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} hz_state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: selects the freshest producer of one EX source operand
module forward_unit
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);
  // MEM holds the younger result, so it wins over WB; x0 never forwards
  always_comb
    sel = (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
          (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)     ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer, operand forwarding and stall counter
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned IMEM_LATENCY = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] perf_stall_cycles
);
  localparam logic [2:0] FL_INIT = 3'(IMEM_LATENCY);
  hz_state_t  state_q, state_d;
  logic [2:0] fl_q, fl_d;
  logic       frozen, load_use;
  logic [1:0] sel_a, sel_b;
  forward_unit u_fwd_a (.rs(ex_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
                        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_a));
  forward_unit u_fwd_b (.rs(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
                        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_b));
  assign fwd_a = rstn ? sel_a : FWD_RF;
  assign fwd_b = rstn ? sel_b : FWD_RF;
  assign frozen   = mem_req && !dmem_ready;
  assign load_use = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  // Next state and strobes, priority freeze > redirect > load-use; the dmem-ready cycle leaving MEM_WAIT is a plain advance
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    fl_d         = fl_q;
    if (!rstn) begin
      state_d = RUN;
    end else if (frozen) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = (state_q == RUN) ? MEM_WAIT : state_q;
    end else if (state_q == MEM_WAIT) begin
      state_d = RUN;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fl_d       = FL_INIT;
      state_d    = (IMEM_LATENCY > 0) ? REDIRECT : RUN;
    end else begin
      if (state_q == REDIRECT) begin
        ifid_flush = 1'b1;
        fl_d       = (fl_q <= 3'd1) ? 3'd0 : fl_q - 3'd1;
        state_d    = (fl_q <= 3'd1) ? RUN : REDIRECT;
      end
      if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end
  // State, flush countdown and wrapping stall-cycle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= RUN;
      fl_q              <= 3'd0;
      perf_stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      if (!pc_en) perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stalls, redirects, freezes, forwarding and reset
module tb_hazard_ctrl;
  localparam logic [6:0] DEF  = 7'b1101010;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] RED0 = 7'b1111110;
  localparam logic [6:0] RED1 = 7'b1111010;
  localparam logic [6:0] RLU  = 7'b0011110;
  localparam logic [6:0] FRZ  = 7'b0000001;
  logic clk = 1'b0, rstn = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, ex_redirect, mem_reg_write, mem_req, dmem_ready, wb_reg_write;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic z_pc_en, z_ifid_en, z_ifid_flush, z_idex_en, z_idex_flush, z_exmem_en, z_memwb_bubble;
  logic [1:0] fwd_a, fwd_b, z_fwd_a, z_fwd_b;
  logic [31:0] perf, z_perf;
  logic [6:0] ctl, z_ctl;
  int errors = 0, checks = 0;
  assign ctl   = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};
  assign z_ctl = {z_pc_en, z_ifid_en, z_ifid_flush, z_idex_en, z_idex_flush, z_exmem_en, z_memwb_bubble};
  always #5 clk = ~clk;
  hazard_ctrl #(.IMEM_LATENCY(1), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .perf_stall_cycles(perf));
  hazard_ctrl #(.IMEM_LATENCY(0), .CNT_W(32)) dut_z (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .pc_en(z_pc_en), .ifid_en(z_ifid_en), .ifid_flush(z_ifid_flush),
    .idex_en(z_idex_en), .idex_flush(z_idex_flush), .exmem_en(z_exmem_en), .memwb_bubble(z_memwb_bubble),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .perf_stall_cycles(z_perf));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, ex_redirect, mem_reg_write, mem_req, dmem_ready, wb_reg_write} = '0;
  endtask
  initial begin
    idle();
    #3;
    chk("reset_ctl", {25'd0, ctl}, {25'd0, DEF});
    chk("reset_perf", perf, 0);
    tick(); rstn = 1'b1;
    tick(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; #2;
    chk("lu_ctl", {25'd0, ctl}, {25'd0, LU});
    chk("lu_perf0", perf, 0);
    tick(); idle(); #2;
    chk("lu_clear", {25'd0, ctl}, {25'd0, DEF});
    chk("lu_perf1", perf, 1);
    tick(); ex_mem_read = 1; #2;
    chk("x0_load", {25'd0, ctl}, {25'd0, DEF});
    tick(); idle(); ex_redirect = 1; #2;
    chk("perf_x0", perf, 1);
    chk("red_c0", {25'd0, ctl}, {25'd0, RED0});
    chk("red_c0_lat0", {25'd0, z_ctl}, {25'd0, RED0});
    tick(); ex_redirect = 0; #2;
    chk("red_c1", {25'd0, ctl}, {25'd0, RED1});
    chk("red_c1_lat0", {25'd0, z_ctl}, {25'd0, DEF});
    tick(); #2;
    chk("red_c2", {25'd0, ctl}, {25'd0, DEF});
    tick(); mem_req = 1; ex_redirect = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; #2;
    chk("frz_1", {25'd0, ctl}, {25'd0, FRZ});
    tick(); #2;
    chk("frz_2", {25'd0, ctl}, {25'd0, FRZ});
    tick(); #2;
    chk("frz_3", {25'd0, ctl}, {25'd0, FRZ});
    tick(); dmem_ready = 1; #2;
    chk("frz_ready", {25'd0, ctl}, {25'd0, DEF});
    chk("frz_perf", perf, 4);
    tick(); mem_req = 0; dmem_ready = 0; #2;
    chk("frz_deferred_red", {25'd0, ctl}, {25'd0, RED0});
    tick(); ex_redirect = 0; #2;
    chk("red_lu", {25'd0, ctl}, {25'd0, RLU});
    chk("red_lu_lat0", {25'd0, z_ctl}, {25'd0, LU});
    tick(); idle(); #2;
    chk("red_lu_perf", perf, 5);
    chk("after_red_lu", {25'd0, ctl}, {25'd0, DEF});
    ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1; #1;
    chk("fwd_mem_wins", {30'd0, fwd_a}, 32'd2);
    mem_req = 1; #1;
    chk("fwd_in_freeze", {30'd0, fwd_a}, 32'd2);
    chk("fwd_freeze_ctl", {25'd0, ctl}, {25'd0, FRZ});
    mem_req = 0; mem_reg_write = 0; #1;
    chk("fwd_wb", {30'd0, fwd_a}, 32'd1);
    ex_rs2 = 7; #1;
    chk("fwd_b_wb", {30'd0, fwd_b}, 32'd1);
    ex_rs2 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; #1;
    chk("fwd_b_x0", {30'd0, fwd_b}, 32'd0);
    chk("fwd_a_none", {30'd0, fwd_a}, 32'd0);
    tick(); idle(); ex_redirect = 1; #2;
    chk("pre_rst_red", {25'd0, ctl}, {25'd0, RED0});
    tick(); ex_redirect = 0; #2;
    chk("in_redirect", {25'd0, ctl}, {25'd0, RED1});
    rstn = 0; #1;
    chk("rst_red_ctl", {25'd0, ctl}, {25'd0, DEF});
    chk("rst_red_perf", perf, 0);
    tick(); rstn = 1;
    ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; #2;
    chk("post_rst_red_run", {25'd0, ctl}, {25'd0, LU});
    tick(); idle(); mem_req = 1; #2;
    chk("pre_rst_frz", {25'd0, ctl}, {25'd0, FRZ});
    tick(); #2;
    chk("frz_perf_nz", perf, 2);
    rstn = 0; #1;
    chk("rst_frz_ctl", {25'd0, ctl}, {25'd0, DEF});
    chk("rst_frz_perf", perf, 0);
    tick(); rstn = 1; mem_req = 0;
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; #2;
    chk("post_rst_frz_run", {25'd0, ctl}, {25'd0, LU});
    tick(); idle(); #2;
    chk("final_perf", perf, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
